// File: rtl/acdc_mc_core.sv
// acdc_mc_core: small multi-cycle accumulator-style core.
// Eight W-bit registers, carry/zero flags, 9-bit instructions {op, a, b}.
// Each instruction runs FETCH -> EXEC (-> MEMRD for LD) and then returns to FETCH.
// The instruction ROM and the data memory are external to the core.
//
// Optional feature: define ACDC_BR_LUT_EN to take BZ/JMP targets from the
// BR_LUT table (entry b). Without it, the target is PC + sign-extended b.
//
// Data memory handshake: dm_addr is valid in EXEC and MEMRD.
// dm_we is a one-cycle write strobe, high only in the EXEC cycle of ST.
// dm_rdata is expected one cycle after dm_addr is presented, which is the MEMRD cycle.
module acdc_mc_core #(
    parameter int                  W      = 8,
    parameter int                  PC_W   = 8,
    parameter logic [8*PC_W-1:0]   BR_LUT = '0
) (
    input  logic            CLK,
    input  logic            start,
    output logic [PC_W-1:0] inst_addr,
    input  logic [8:0]      inst_in,
    output logic [W-1:0]    dm_addr,
    output logic [W-1:0]    dm_wdata,
    output logic            dm_we,
    input  logic [W-1:0]    dm_rdata,
    output logic            halt,
    output logic [15:0]     cycle_ct,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEMRD  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [8:0]        ir;
    logic              sc;
    logic              zf;
    logic [W-1:0]      rf [8];

    logic [2:0]        op;
    logic [2:0]        fa;
    logic [2:0]        fb;
    logic [W-1:0]      ra;
    logic [W-1:0]      rb;
    logic [W:0]        sum;
    logic              carry_in;
    logic [W-1:0]      alu_res;
    logic              alu_c;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   br_tgt;
    logic              is_st;

    assign op     = ir[8:6];
    assign fa     = ir[5:3];
    assign fb     = ir[2:0];
    assign ra     = rf[fa];
    assign rb     = rf[fb];
    assign pc_inc = pc + PC_W'(1);

`ifdef ACDC_BR_LUT_EN
    assign br_tgt = BR_LUT[fb*PC_W +: PC_W];
`else
    assign br_tgt = pc + {{(PC_W-3){fb[2]}}, fb};
`endif

    // ALU: ADD/ADC share one adder; XOR and SHL override the result and carry.
    always_comb begin
        carry_in = (op == 3'b001) ? sc : 1'b0;
        sum      = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, carry_in};
        alu_res  = sum[W-1:0];
        alu_c    = sum[W];
        case (op)
            3'b010: begin
                alu_res = ra ^ rb;
                alu_c   = sc;
            end
            3'b011: begin
                alu_res = {ra[W-2:0], sc};
                alu_c   = ra[W-1];
            end
            default: ;
        endcase
    end

    // Memory-side and status outputs decoded from registered state and ir only.
    assign is_st     = (state == S_EXEC) && (op == 3'b111) && (fa == 3'b000);
    assign dm_we     = is_st;
    assign dm_wdata  = is_st ? rf[0] : '0;
    assign dm_addr   = ((state == S_EXEC) || (state == S_MEMRD)) ? rb : '0;
    assign inst_addr = pc;
    assign halt      = (state == S_HALTED);
    assign dbg_state = state;

    // Control FSM and architectural state; start wins over everything, including MEMRD.
    always_ff @(posedge CLK) begin
        if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            sc    <= 1'b0;
            zf    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= inst_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc_inc;
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            rf[fa] <= alu_res;
                            sc     <= alu_c;
                            zf     <= (alu_res == '0);
                        end
                        3'b100: rf[fa] <= rb;
                        3'b101: rf[fa] <= {{(W-3){1'b0}}, fb};
                        3'b110: state  <= S_MEMRD;
                        default: begin
                            case (fa)
                                3'b001: if (zf) pc <= br_tgt;
                                3'b010: pc <= br_tgt;
                                3'b011: sc <= 1'b0;
                                3'b111: begin
                                    pc    <= pc;
                                    state <= S_HALTED;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                S_MEMRD: begin
                    rf[fa] <= dm_rdata;
                    state  <= S_FETCH;
                end
                default: state <= S_HALTED;
            endcase
        end
    end

    // Free-running cycle counter, frozen while halted, wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (start) begin
            cycle_ct <= '0;
        end else if (state != S_HALTED) begin
            cycle_ct <= cycle_ct + 16'd1;
        end
    end

endmodule

// File: tb/tb_acdc_mc_core.sv
// tb_acdc_mc_core: directed programs for acdc_mc_core with a store scoreboard
// (expected {dm_addr, dm_wdata} pairs) and an optional PC trace scoreboard.
module tb_acdc_mc_core;

    localparam logic [8:0] HALT_I = 9'b111_111_000;
    localparam logic [8:0] NOP_I  = 9'b111_100_000;
    localparam int ST_FETCH = 0;
    localparam int ST_EXEC  = 1;
    localparam int ST_MEMRD = 2;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic start;
    logic start4;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- DUT (W=8, PC_W=8) ----------------
    logic [7:0]  inst_addr;
    logic [8:0]  inst_in;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic        dm_we;
    logic [7:0]  dm_rdata;
    logic        halt;
    logic [15:0] cycle_ct;
    logic [1:0]  dbg_state;

    logic [8:0]  rom [256];
    logic [7:0]  dmem [256];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [7:0]  pre_data;

    acdc_mc_core #(.W(8), .PC_W(8), .BR_LUT(64'h0000_0000_0020_0000)) dut (
        .CLK(CLK), .start(start), .inst_addr(inst_addr), .inst_in(inst_in),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .halt(halt), .cycle_ct(cycle_ct), .dbg_state(dbg_state)
    );

    assign inst_in = rom[inst_addr];

    always @(posedge CLK) begin
        dm_rdata <= dmem[dm_addr];
        if (pre_en) dmem[pre_addr] <= pre_data;
        else if (dm_we) dmem[dm_addr] <= dm_wdata;
    end

    // ---------------- DUT (PC_W=4) for PC wrap ----------------
    logic [3:0]  inst_addr4;
    logic [8:0]  inst_in4;
    logic [7:0]  dm_addr4;
    logic [7:0]  dm_wdata4;
    logic        dm_we4;
    logic [7:0]  dm_rdata4;
    logic        halt4;
    logic [15:0] cycle_ct4;
    logic [1:0]  dbg_state4;

    acdc_mc_core #(.W(8), .PC_W(4)) dut4 (
        .CLK(CLK), .start(start4), .inst_addr(inst_addr4), .inst_in(inst_in4),
        .dm_addr(dm_addr4), .dm_wdata(dm_wdata4), .dm_we(dm_we4), .dm_rdata(dm_rdata4),
        .halt(halt4), .cycle_ct(cycle_ct4), .dbg_state(dbg_state4)
    );

    assign inst_in4  = NOP_I;
    assign dm_rdata4 = 8'h00;

    // ---------------- scoreboard ----------------
    int checks;
    int errors;
    logic [15:0] exp_q[$];
    logic [7:0]  pc_q[$];
    logic mon_en;
    logic trace_en;
    logic prev_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every store strobe pops one expected {addr, data}; PC trace pops per EXEC cycle.
    always @(negedge CLK) begin
        if (mon_en && !start) begin
            if (dm_we) begin
                check("store strobe single cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected store", {dm_addr, dm_wdata}, 32'hFFFF_FFFF);
                end else begin
                    check("store addr/data", {16'd0, dm_addr, dm_wdata}, {16'd0, exp_q.pop_front()});
                end
            end
            if (trace_en && dbg_state == 2'(ST_EXEC)) begin
                if (pc_q.size() == 0) begin
                    check("unexpected exec pc", {24'd0, inst_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("exec pc trace", {24'd0, inst_addr}, {24'd0, pc_q.pop_front()});
                end
            end
        end
        prev_we = dm_we;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [8:0] enc(input int op, input int a, input int b);
        logic [31:0] o, x, y;
        o = op; x = a; y = b;
        return {o[2:0], x[2:0], y[2:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HALT_I;
    endtask

    task automatic mem_put(input logic [7:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge CLK);
        pre_en = 1'b0;
    endtask

    // Two active edges with start high, ending at a negedge with start still high.
    task automatic hold_reset();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_until_halt(input string name, input int max);
        bit found;
        found = 1'b0;
        start = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (halt) begin
                found = 1'b1;
                break;
            end
        end
        check({name, " halt reached"}, {31'd0, found}, 32'd1);
        check({name, " store queue drained"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        checks = 0; errors = 0;
        start = 1'b1; start4 = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        mon_en = 1'b0; trace_en = 1'b0; prev_we = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_put(i[7:0], 8'h00);
        end

        // Arbitrary prior state, then reset mid-run.
        clear_rom();
        rom[0] = enc(5, 1, 7); rom[1] = enc(5, 2, 5); rom[2] = enc(5, 3, 3);
        rom[3] = enc(5, 4, 4); rom[4] = enc(5, 5, 5); rom[5] = enc(5, 6, 6);
        rom[6] = enc(5, 7, 7); rom[7] = enc(0, 1, 2); rom[8] = enc(3, 1, 1);
        rom[9] = enc(4, 0, 1); rom[10] = enc(7, 2, 0);
        @(negedge CLK);
        start = 1'b0;
        repeat ($urandom_range(8, 25)) @(negedge CLK);
        hold_reset();
        check("reset pc", {24'd0, inst_addr}, 32'd0);
        check("reset halt", {31'd0, halt}, 32'd0);
        check("reset cycle_ct", {16'd0, cycle_ct}, 32'd0);
        check("reset dm_we", {31'd0, dm_we}, 32'd0);
        check("reset dm_addr", {24'd0, dm_addr}, 32'd0);
        check("reset state", {30'd0, dbg_state}, ST_FETCH);
        mon_en = 1'b1;

        // Registers and carry cleared: every probe stores zero at address zero.
        clear_rom();
        rom[0] = enc(7, 0, 1);
        rom[1] = enc(4, 0, 2); rom[2] = enc(7, 0, 3);
        rom[3] = enc(4, 0, 7); rom[4] = enc(7, 0, 5);
        rom[5] = enc(1, 4, 6); rom[6] = enc(4, 0, 4); rom[7] = enc(7, 0, 6);
        repeat (4) exp_q.push_back(16'h0000);
        run_until_halt("reset regs", 60);

        // LDI r1,7; LDI r2,1; ADD r1,r2; HALT -> 8 cycles then frozen.
        hold_reset();
        clear_rom();
        rom[0] = enc(5, 1, 7); rom[1] = enc(5, 2, 1); rom[2] = enc(0, 1, 2);
        run_until_halt("basic", 40);
        check("basic cycle_ct at halt", {16'd0, cycle_ct}, 32'd8);
        repeat (5) @(negedge CLK);
        check("basic cycle_ct frozen", {16'd0, cycle_ct}, 32'd8);
        check("basic halt held", {31'd0, halt}, 32'd1);
        check("basic pc held at halt", {24'd0, inst_addr}, 32'd3);

        // Same arithmetic with probes: r1=8, zf=0 (BZ not taken), sc=0 (ADC of zeros).
        hold_reset();
        clear_rom();
        rom[0] = enc(5, 1, 7); rom[1] = enc(5, 2, 1); rom[2] = enc(0, 1, 2);
`ifdef ACDC_BR_LUT_EN
        rom[3] = NOP_I;
`else
        rom[3] = enc(7, 1, 2);
`endif
        rom[4] = enc(4, 0, 1); rom[5] = enc(7, 0, 6);
        rom[6] = enc(1, 3, 3); rom[7] = enc(4, 0, 3); rom[8] = enc(7, 0, 6);
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0000);
        run_until_halt("add probes", 60);

        // Carry chain: r1=0xFF from memory, +1 -> 0 with sc=1 zf=1; ADC r3,r0 -> 1, sc=0.
        hold_reset();
        mem_put(8'h05, 8'hFF);
        clear_rom();
        rom[0] = enc(5, 7, 5); rom[1] = enc(6, 1, 7); rom[2] = enc(5, 2, 1);
        rom[3] = enc(0, 1, 2);
`ifdef ACDC_BR_LUT_EN
        rom[4] = NOP_I; rom[5] = NOP_I;
`else
        rom[4] = enc(7, 1, 2); rom[5] = enc(5, 0, 7);
`endif
        rom[6] = enc(1, 3, 0); rom[7] = enc(4, 0, 3); rom[8] = enc(7, 0, 6);
        rom[9] = enc(4, 0, 1); rom[10] = enc(7, 0, 6);
        rom[11] = enc(1, 4, 4); rom[12] = enc(4, 0, 4); rom[13] = enc(7, 0, 6);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        run_until_halt("carry chain", 80);

        // Memory: ST 0x5A to addr 3, LD it back into r4, probe r4 at addr 2.
        hold_reset();
        mem_put(8'h01, 8'h5A);
        clear_rom();
        rom[0] = enc(5, 7, 1); rom[1] = enc(6, 0, 7); rom[2] = enc(5, 3, 3);
        rom[3] = enc(7, 0, 3); rom[4] = enc(6, 4, 3); rom[5] = enc(5, 0, 0);
        rom[6] = enc(4, 0, 4); rom[7] = enc(5, 5, 2); rom[8] = enc(7, 0, 5);
        exp_q.push_back(16'h035A);
        exp_q.push_back(16'h025A);
        run_until_halt("memory", 60);

        // start during MEMRD of LD r4 must discard the load.
        hold_reset();
        clear_rom();
        rom[0] = enc(5, 3, 3); rom[1] = enc(6, 4, 3);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (dbg_state == 2'(ST_MEMRD)) begin
                found = 1'b1;
                break;
            end
        end
        check("abort reached MEMRD", {31'd0, found}, 32'd1);
        check("abort MEMRD dm_addr", {24'd0, dm_addr}, 32'd3);
        start = 1'b1;
        @(negedge CLK);
        check("abort state after start", {30'd0, dbg_state}, ST_FETCH);
        clear_rom();
        rom[0] = enc(4, 0, 4); rom[1] = enc(7, 0, 1);
        exp_q.push_back(16'h0000);
        @(negedge CLK);
        run_until_halt("abort r4 clear", 30);

`ifndef ACDC_BR_LUT_EN
        // BZ -2 at PC 5: taken (zf=1) to 3, then not taken (zf=0) to 6.
        hold_reset();
        clear_rom();
        rom[0] = enc(5, 1, 1); rom[1] = enc(5, 2, 1); rom[2] = NOP_I; rom[3] = NOP_I;
        rom[4] = enc(2, 1, 2); rom[5] = enc(7, 1, 6);
        pc_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd3, 8'd4, 8'd5, 8'd6};
        trace_en = 1'b1;
        run_until_halt("bz trace", 60);
        trace_en = 1'b0;
        check("bz trace drained", pc_q.size(), 32'd0);
`endif

        // JMP b=2 from PC 0.
        hold_reset();
        clear_rom();
        rom[0] = enc(7, 2, 2);
`ifdef ACDC_BR_LUT_EN
        pc_q = '{8'd0, 8'h20};
`else
        pc_q = '{8'd0, 8'd2};
`endif
        trace_en = 1'b1;
        run_until_halt("jmp", 20);
        trace_en = 1'b0;
        check("jmp trace drained", pc_q.size(), 32'd0);

        // PC_W=4 wrap: NOP at 15 -> 0.
        @(negedge CLK);
        start4 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (dbg_state4 == 2'(ST_EXEC) && inst_addr4 == 4'd15) begin
                found = 1'b1;
                break;
            end
        end
        check("pc4 reached 15", {31'd0, found}, 32'd1);
        @(negedge CLK);
        check("pc4 wrap to 0", {28'd0, inst_addr4}, 32'd0);
        start4 = 1'b1;

        // cycle_ct wrap: self-loop JMP b=0 until 0xFFFF, then 0.
        hold_reset();
        clear_rom();
        rom[0] = enc(7, 2, 0);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge CLK);
            if (cycle_ct == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
        end
        check("cycle_ct reached ffff", {31'd0, found}, 32'd1);
        @(negedge CLK);
        check("cycle_ct wrap to 0", {16'd0, cycle_ct}, 32'd0);
        check("cycle_ct wrap not halted", {31'd0, halt}, 32'd0);
        start = 1'b1;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
